// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
// Modes are encoded as {CPOL, CPHA}.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a third register for edge detection.
// Edges are reported while stage 2 and stage 3 disagree.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slave_n.sv
// SPI slave, all four modes, WIDTH-bit words, oversampled on clk.
// Transmit side uses a one-word holding register ahead of the shifter.
module spi_slave_n
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 1,
    parameter int CPHA      = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             frame_err,
    output logic             tx_underrun
);

    localparam logic [1:0] MODE = {CPOL != 0, CPHA != 0};
    localparam logic SAMPLE_RISE = (MODE == MODE0) || (MODE == MODE3);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int TX_BIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    spi_state_t state;
    spi_state_t state_nxt;

    logic sclk_lvl;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_sync;
    logic mosi_rise;
    logic mosi_fall;
    logic ss_sync;
    logic ss_rise;
    logic ss_fall;
    logic unused_sync;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] hold;
    logic             word_done;

    logic in_shift;
    logic abort;
    logic do_sample;
    logic do_shift;
    logic word_start;
    logic advance;
    logic load_ok;

    spi_sync #(.RST_VAL(CPOL != 0)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .dout (mosi_sync),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    spi_sync #(.RST_VAL(1'b1)) u_ss (
        .clk  (clk),
        .rst  (rst),
        .din  (ss),
        .dout (ss_sync),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    assign in_shift  = (state == SHIFT);
    assign abort     = in_shift & ss_rise;
    assign do_sample = in_shift & ~ss_rise
                     & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign do_shift  = in_shift & ~ss_rise
                     & (SAMPLE_RISE ? sclk_fall : sclk_rise);

    // CPHA=0 must present bit 0 before the first sample edge.
    assign word_start = (CPHA == 0)
                      ? ((state == IDLE) & ss_fall)
                      : (do_shift & (cnt == '0));
    assign advance    = do_shift & ~word_start;
    assign load_ok    = tx_load & (tx_ready | word_start);

    assign rx_next = (MSB_FIRST != 0)
                   ? {rx_sr[WIDTH-2:0], mosi_sync}
                   : {mosi_sync, rx_sr[WIDTH-1:1]};
    assign tx_next = (MSB_FIRST != 0)
                   ? {tx_sr[WIDTH-2:0], 1'b0}
                   : {1'b0, tx_sr[WIDTH-1:1]};

    assign miso_oe = ~ss_sync;
    assign miso    = miso_oe & tx_sr[TX_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            hold        <= '0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            word_done   <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            word_done   <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            if (word_done) begin
                rx_data <= rx_sr;
            end

            if (abort) begin
                cnt       <= '0;
                rx_sr     <= '0;
                frame_err <= (cnt != '0);
            end else if (do_sample) begin
                rx_sr <= rx_next;
                if (cnt == LAST) begin
                    cnt       <= '0;
                    word_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // An empty holding register sends a zero word.
            if (abort) begin
                tx_sr <= '0;
            end else if (word_start) begin
                tx_sr       <= tx_ready ? '0 : hold;
                tx_underrun <= tx_ready;
            end else if (advance) begin
                tx_sr <= tx_next;
            end

            if (load_ok) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end else if (word_start) begin
                tx_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_n.sv
// Directed bench for spi_slave_n across four parameterisations.
// Shared sclk/mosi; each instance has its own slave select.
module tb_spi_slave_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b1;
    logic mosi = 1'b0;
    logic ss_a = 1'b1;
    logic ss_b = 1'b1;
    logic ss_c = 1'b1;
    logic ss_d = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_load_a = 1'b0;
    logic tx_load_b = 1'b0;
    logic tx_load_c = 1'b0;
    logic tx_load_d = 1'b0;

    logic       miso_a, miso_oe_a, rx_valid_a, tx_ready_a, ferr_a_p, und_a_p;
    logic [3:0] rx_data_a;
    logic       miso_b, miso_oe_b, rx_valid_b, tx_ready_b, ferr_b_p, und_b_p;
    logic [7:0] rx_data_b;
    logic       miso_c, miso_oe_c, rx_valid_c, tx_ready_c, ferr_c_p, und_c_p;
    logic [7:0] rx_data_c;
    logic       miso_d, miso_oe_d, rx_valid_d, tx_ready_d, ferr_d_p, und_d_p;
    logic [7:0] rx_data_d;

    int checks = 0;
    int failures = 0;
    int sel = 0;
    int rxv_a = 0, ferr_a = 0;
    int rxv_b = 0, ferr_b = 0, und_b = 0;
    int rxv_c = 0, ferr_c = 0, und_c = 0;
    logic [7:0] rxq_c[$];
    logic miso_sel;

    always #5 clk = ~clk;

    spi_slave_n #(.WIDTH(4), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss_a),
        .miso(miso_a), .miso_oe(miso_oe_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_data(tx_data[3:0]), .tx_load(tx_load_a), .tx_ready(tx_ready_a),
        .frame_err(ferr_a_p), .tx_underrun(und_a_p)
    );

    spi_slave_n #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss_b),
        .miso(miso_b), .miso_oe(miso_oe_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_data(tx_data), .tx_load(tx_load_b), .tx_ready(tx_ready_b),
        .frame_err(ferr_b_p), .tx_underrun(und_b_p)
    );

    spi_slave_n u_c (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss_c),
        .miso(miso_c), .miso_oe(miso_oe_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .tx_data(tx_data), .tx_load(tx_load_c), .tx_ready(tx_ready_c),
        .frame_err(ferr_c_p), .tx_underrun(und_c_p)
    );

    spi_slave_n #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_d (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss_d),
        .miso(miso_d), .miso_oe(miso_oe_d),
        .rx_data(rx_data_d), .rx_valid(rx_valid_d),
        .tx_data(tx_data), .tx_load(tx_load_d), .tx_ready(tx_ready_d),
        .frame_err(ferr_d_p), .tx_underrun(und_d_p)
    );

    always_comb begin
        miso_sel = miso_a;
        case (sel)
            1: miso_sel = miso_b;
            2: miso_sel = miso_c;
            3: miso_sel = miso_d;
            default: miso_sel = miso_a;
        endcase
    end

    always @(posedge clk) begin
        if (rx_valid_a) rxv_a <= rxv_a + 1;
        if (ferr_a_p)   ferr_a <= ferr_a + 1;
        if (rx_valid_b) rxv_b <= rxv_b + 1;
        if (ferr_b_p)   ferr_b <= ferr_b + 1;
        if (und_b_p)    und_b <= und_b + 1;
        if (ferr_c_p)   ferr_c <= ferr_c + 1;
        if (und_c_p)    und_c <= und_c + 1;
        if (rx_valid_c) begin
            rxv_c <= rxv_c + 1;
            rxq_c.push_back(rx_data_c);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    // m0: mode 0 timing, else mode 3. Bits sent from w[7] downward.
    task automatic xfer(input bit m0, input logic [7:0] w, input int n,
                        output logic [7:0] mb);
        mb = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (m0) begin
                mosi = w[7-k];
                half();
                mb[7-k] = miso_sel;
                sclk = 1'b1;
                half();
                sclk = 1'b0;
            end else begin
                sclk = 1'b0;
                mosi = w[7-k];
                half();
                mb[7-k] = miso_sel;
                sclk = 1'b1;
                if (k != n - 1) half();
            end
        end
    endtask

    initial begin
        logic [7:0] mb;
        logic [7:0] m1;
        logic [7:0] m2;
        int u0;
        int f0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        half();
        chk("rst_tx_ready", tx_ready_c, 1'b1);
        chk("rst_rx_data", rx_data_c, 8'h00);
        chk("rst_miso_oe", miso_oe_c, 1'b0);
        chk("rst_miso", miso_c, 1'b0);
        chk("rst_rx_valid", rx_valid_c, 1'b0);

        // Mode 3, 4-bit word, latency from the last sampling edge
        sel = 0;
        ss_a = 1'b0;
        half();
        xfer(1'b0, 8'h10, 4, mb);
        repeat (3) @(posedge clk);
        #1 chk("a_lat_e3", rx_valid_a, 1'b0);
        @(posedge clk);
        #1 chk("a_lat_e4", rx_valid_a, 1'b1);
        chk("a_rx_data", rx_data_a, 4'h1);
        @(posedge clk);
        #1 chk("a_pulse_end", rx_valid_a, 1'b0);
        half();
        ss_a = 1'b1;
        half();
        chk("a_rxv_count", rxv_a, 1);
        chk("a_ferr_count", ferr_a, 0);

        // Mode 0 with a preloaded transmit word
        sclk = 1'b0;
        half();
        tx_data = 8'hA5;
        tx_load_b = 1'b1;
        @(negedge clk);
        tx_load_b = 1'b0;
        chk("b_ready_lo", tx_ready_b, 1'b0);
        ss_b = 1'b0;
        half();
        chk("b_ready_hi", tx_ready_b, 1'b1);
        chk("b_oe_hi", miso_oe_b, 1'b1);
        sel = 1;
        xfer(1'b1, 8'h3C, 8, mb);
        half();
        chk("b_miso", mb, 8'hA5);
        chk("b_rx_data", rx_data_b, 8'h3C);
        chk("b_rxv_count", rxv_b, 1);
        chk("b_und_count", und_b, 0);
        ss_b = 1'b1;
        half();
        chk("b_oe_lo", miso_oe_b, 1'b0);
        chk("b_ferr_count", ferr_b, 0);
        sclk = 1'b1;
        half();

        // LSB first; second load while holding is full must be ignored
        tx_data = 8'h35;
        tx_load_d = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        @(negedge clk);
        tx_load_d = 1'b0;
        chk("d_ready_lo", tx_ready_d, 1'b0);
        ss_d = 1'b0;
        half();
        sel = 3;
        xfer(1'b0, 8'h80, 8, mb);
        half();
        chk("d_rx_data", rx_data_d, 8'h01);
        chk("d_miso", mb, 8'hAC);
        ss_d = 1'b1;
        half();

        // Partial word then a full word
        sel = 2;
        ss_c = 1'b0;
        half();
        xfer(1'b0, 8'hA8, 5, mb);
        half();
        ss_c = 1'b1;
        half();
        chk("c_ferr_once", ferr_c, 1);
        chk("c_no_rxv", rxv_c, 0);
        chk("c_rx_kept", rx_data_c, 8'h00);
        ss_c = 1'b0;
        half();
        xfer(1'b0, 8'hFF, 8, mb);
        half();
        chk("c_rx_ff", rx_data_c, 8'hFF);
        chk("c_rxv_one", rxv_c, 1);
        ss_c = 1'b1;
        half();
        chk("c_ferr_still", ferr_c, 1);

        // Back-to-back words, nothing loaded
        u0 = und_c;
        ss_c = 1'b0;
        half();
        xfer(1'b0, 8'h12, 8, m1);
        half();
        xfer(1'b0, 8'h34, 8, m2);
        half();
        ss_c = 1'b1;
        half();
        chk("c_b2b_count", rxv_c, 3);
        chk("c_b2b_w1", rxq_c[1], 8'h12);
        chk("c_b2b_w2", rxq_c[2], 8'h34);
        chk("c_b2b_miso1", m1, 8'h00);
        chk("c_b2b_miso2", m2, 8'h00);
        chk("c_b2b_und", und_c - u0, 2);
        chk("c_b2b_ferr", ferr_c, 1);

        // Reset mid-word, then a clean word
        f0 = ferr_c;
        ss_c = 1'b0;
        half();
        xfer(1'b0, 8'hE0, 3, mb);
        half();
        rst = 1'b1;
        ss_c = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("c_rst_rx", rx_data_c, 8'h00);
        half();
        ss_c = 1'b0;
        half();
        xfer(1'b0, 8'h81, 8, mb);
        half();
        chk("c_rx_81", rx_data_c, 8'h81);
        chk("c_q_81", rxq_c[3], 8'h81);
        ss_c = 1'b1;
        half();
        chk("c_rst_no_ferr", ferr_c - f0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
